// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: 4-cycle IDLE/DECODE/EXEC/WB issue sequencer with regfile in front of a 64-bit combinational ALU.
//   clk, rst (async, active-high); instr_valid/instr_ready/instr: instruction handshake;
//   alu_op, operand1, operand2, imm_val, imm_type: registered ALU inputs; result + zero/sign/overflow flags: ALU outputs;
//   wb_valid/wb_rd/wb_data: write-back pulse; flags_q: {ovf,sign,zero} of last retire; illegal_op: trap pulse;
//   dbg_addr/dbg_data: combinational regfile peek. Macro ILLEGAL_TRAP_EN enables illegal-combination trapping.
module alu_issue_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int IMM_W = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [5:0]  alu_op,
  output logic [63:0] operand1,
  output logic [63:0] operand2,
  output logic [63:0] imm_val,
  output logic [1:0]  imm_type,
  input  logic [63:0] result,
  input  logic        zero_flag,
  input  logic        sign_flag,
  input  logic        overflow_flag,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic [2:0]  flags_q,
  output logic        illegal_op,
  input  logic [4:0]  dbg_addr,
  output logic [63:0] dbg_data
);
  localparam int AW = $clog2(NUM_REGS);
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
  state_t state_q, state_d;
  logic [31:0] instr_q;
  logic [63:0] regs [NUM_REGS];
  logic [2:0]  flag_s;
  logic [5:0]  op;
  logic [1:0]  typ;
  logic [4:0]  rd, rs1, rs2;
  logic [63:0] imm_s, imm_z, r1_val, r2_val;
  logic        wr_en;
  assign op    = instr_q[31:26];
  assign typ   = instr_q[25:24];
  assign rd    = instr_q[23:19];
  assign rs1   = instr_q[18:14];
  assign rs2   = instr_q[13:9];
  assign imm_s = {{(64-IMM_W){instr_q[IMM_W-1]}}, instr_q[IMM_W-1:0]};
  assign imm_z = {{(64-IMM_W){1'b0}}, instr_q[IMM_W-1:0]};
  assign r1_val   = (rs1 != 5'd0 && {1'b0, rs1} < 6'(NUM_REGS)) ? regs[rs1[AW-1:0]] : '0;
  assign r2_val   = (rs2 != 5'd0 && {1'b0, rs2} < 6'(NUM_REGS)) ? regs[rs2[AW-1:0]] : '0;
  assign dbg_data = (dbg_addr != 5'd0 && {1'b0, dbg_addr} < 6'(NUM_REGS)) ? regs[dbg_addr[AW-1:0]] : '0;
  assign instr_ready = state_q == IDLE && !rst;
  assign wb_rd = rd;
  assign wr_en = wb_valid && rd != 5'd0 && {1'b0, rd} < 6'(NUM_REGS);
`ifdef ILLEGAL_TRAP_EN
  logic legal, ill_q;
  always_comb
    legal = (typ == 2'b00 || typ == 2'b10) ? (op inside {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd7}) :
            typ == 2'b01 ? (op inside {6'd1, 6'd2, 6'd3, 6'd4}) : 1'b0;
  always_ff @(posedge clk or posedge rst)
    if (rst) ill_q <= 1'b0;
    else if (state_q == DECODE) ill_q <= !legal;
  assign illegal_op = state_q == WB && ill_q;
  assign wb_valid   = state_q == WB && !ill_q;
`else
  assign illegal_op = 1'b0;
  assign wb_valid   = state_q == WB;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (instr_valid ? DECODE : IDLE) :
              state_q == DECODE ? EXEC :
              state_q == EXEC ? WB : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      instr_q  <= '0;
      alu_op   <= '0;
      operand1 <= '0;
      operand2 <= '0;
      imm_val  <= '0;
      imm_type <= '0;
      wb_data  <= '0;
      flag_s   <= '0;
      flags_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (state_q == IDLE && instr_valid) instr_q <= instr;
      if (state_q == DECODE) begin
        alu_op   <= op;
        imm_type <= typ;
        operand1 <= r1_val;
        operand2 <= typ == 2'b10 ? imm_s : r2_val;
        imm_val  <= typ == 2'b01 ? imm_z : imm_s;
      end
      if (state_q == EXEC) begin
        wb_data <= result;
        flag_s  <= {overflow_flag, sign_flag, zero_flag};
      end
      if (wr_en) regs[rd[AW-1:0]] <= wb_data;
      if (wb_valid) flags_q <= flag_s;
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed self-checking bench for alu_issue_ctrl with a behavioural ALU model.
module tb_alu_issue_ctrl;
  logic        clk = 1'b0, rst = 1'b1, instr_valid = 1'b0;
  logic        instr_ready, wb_valid, illegal_op;
  logic [31:0] instr = '0;
  logic [5:0]  alu_op;
  logic [63:0] operand1, operand2, imm_val, result, wb_data, dbg_data;
  logic [1:0]  imm_type;
  logic        zero_flag, sign_flag, overflow_flag;
  logic [4:0]  wb_rd, dbg_addr = '0;
  logic [2:0]  flags_q;
  int vecs = 0, errs = 0;
  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_op(alu_op), .operand1(operand1), .operand2(operand2), .imm_val(imm_val), .imm_type(imm_type),
    .result(result), .zero_flag(zero_flag), .sign_flag(sign_flag), .overflow_flag(overflow_flag),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flags_q(flags_q), .illegal_op(illegal_op),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  always #5 clk = ~clk;
  always_comb begin
    result = alu_op == 6'd1 ? operand1 + operand2 :
             alu_op == 6'd2 ? operand1 - operand2 :
             alu_op == 6'd3 ? operand1 & operand2 :
             alu_op == 6'd4 ? operand1 | operand2 :
             alu_op == 6'd5 ? operand1 ^ operand2 :
             alu_op == 6'd7 ? operand1 << operand2[5:0] : 64'd0;
    zero_flag = result == 64'd0;
    sign_flag = result[63];
    overflow_flag = alu_op == 6'd1 ? (operand1[63] == operand2[63] && result[63] != operand1[63]) :
                    alu_op == 6'd2 ? (operand1[63] != operand2[63] && result[63] != operand1[63]) : 1'b0;
  end
  function automatic logic [31:0] mk(input logic [5:0] op, input logic [1:0] t, input logic [4:0] d,
                                     input logic [4:0] s1, input logic [13:0] lo);
    return {op, t, d, s1, lo};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic dbg(input logic [4:0] a, input logic [63:0] exp, input string tag);
    dbg_addr = a;
    #1 chk(tag, dbg_data, exp);
  endtask
  task automatic issue(input string tag, input logic [31:0] w, input logic exp_wb, input logic exp_ill,
                       input logic [4:0] exp_rd, input logic [63:0] exp_data, input logic [2:0] exp_flags);
    chk({tag, "_ready_pre"}, 64'(instr_ready), 64'd1);
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    chk({tag, "_ready_dec"}, 64'(instr_ready), 64'd0);
    @(posedge clk);
    #1 chk({tag, "_ready_exec"}, 64'(instr_ready), 64'd0);
    chk({tag, "_wbv_exec"}, 64'(wb_valid), 64'd0);
    @(posedge clk);
    #1 chk({tag, "_ready_wb"}, 64'(instr_ready), 64'd0);
    chk({tag, "_wb_valid"}, 64'(wb_valid), 64'(exp_wb));
    chk({tag, "_illegal"}, 64'(illegal_op), 64'(exp_ill));
    if (exp_wb) begin
      chk({tag, "_wb_rd"}, 64'(wb_rd), 64'(exp_rd));
      chk({tag, "_wb_data"}, wb_data, exp_data);
    end
    @(posedge clk);
    #1 chk({tag, "_wbv_after"}, 64'(wb_valid), 64'd0);
    chk({tag, "_flags"}, 64'(flags_q), 64'(exp_flags));
    chk({tag, "_ready_idle"}, 64'(instr_ready), 64'd1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 chk("rst_ready", 64'(instr_ready), 64'd0);
    chk("rst_wbv", 64'(wb_valid), 64'd0);
    chk("rst_flags", 64'(flags_q), 64'd0);
    chk("rst_op1", operand1, 64'd0);
    chk("rst_aluop", 64'(alu_op), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("rst_release_ready", 64'(instr_ready), 64'd1);
    issue("add_imm5", mk(6'd1, 2'b10, 5'd1, 5'd0, 14'd5), 1'b1, 1'b0, 5'd1, 64'd5, 3'b000);
    dbg(5'd1, 64'd5, "dbg_r1");
    issue("add_neg1", mk(6'd1, 2'b10, 5'd2, 5'd0, 14'h3FFF), 1'b1, 1'b0, 5'd2, '1, 3'b010);
    chk("imm_sext", imm_val, '1);
    chk("op2_sext", operand2, '1);
    dbg(5'd2, '1, "dbg_r2");
    issue("sub_r1r1", mk(6'd2, 2'b00, 5'd3, 5'd1, {5'd1, 9'd0}), 1'b1, 1'b0, 5'd3, 64'd0, 3'b001);
    issue("add_rd0", mk(6'd1, 2'b10, 5'd0, 5'd0, 14'd7), 1'b1, 1'b0, 5'd0, 64'd7, 3'b000);
    dbg(5'd0, 64'd0, "dbg_r0");
    issue("add_zext", mk(6'd1, 2'b01, 5'd5, 5'd1, 14'h3FFF), 1'b1, 1'b0, 5'd5, 64'd5, 3'b000);
    chk("imm_zext", imm_val, 64'h3FFF);
    chk("imm_type", 64'(imm_type), 64'd1);
    dbg(5'd5, 64'd5, "dbg_r5");
    instr = mk(6'd1, 2'b10, 5'd1, 5'd0, 14'd9);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("midrst_ready", 64'(instr_ready), 64'd0);
    dbg(5'd1, 64'd0, "midrst_r1");
    dbg(5'd2, 64'd0, "midrst_r2");
    @(posedge clk);
    #1 chk("midrst_wbv", 64'(wb_valid), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("midrst_wbv2", 64'(wb_valid), 64'd0);
    chk("midrst_ready_after", 64'(instr_ready), 64'd1);
    dbg(5'd1, 64'd0, "midrst_r1_after");
    issue("load_r4", mk(6'd1, 2'b10, 5'd4, 5'd0, 14'd3), 1'b1, 1'b0, 5'd4, 64'd3, 3'b000);
`ifdef ILLEGAL_TRAP_EN
    issue("illegal", mk(6'd9, 2'b00, 5'd4, 5'd4, {5'd4, 9'd0}), 1'b0, 1'b1, 5'd4, 64'd0, 3'b000);
    dbg(5'd4, 64'd3, "illegal_r4");
`else
    issue("illegal", mk(6'd9, 2'b00, 5'd4, 5'd4, {5'd4, 9'd0}), 1'b1, 1'b0, 5'd4, 64'd0, 3'b001);
    dbg(5'd4, 64'd0, "illegal_r4");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencer in front of the 64-bit combinational ALU: accepts one 32-bit instruction per valid/ready handshake and decodes it.
- Reads source operands from an internal register file and drives the ALU opcode, operand and immediate inputs from registers.
- Captures the ALU result and flags, then writes the result back and updates the architectural flag register.
- Non-pipelined, fixed 4-cycle occupancy per instruction.

Parameters:
- NUM_REGS, 32, register file depth; legal values 8/16/32; register 0 reads as zero.
- IMM_W, 14, immediate field width in the instruction word.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous reset, active-high
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block idle, can accept
- instr  in  32  [31:26] alu_op, [25:24] imm_type, [23:19] rd, [18:14] rs1, [13:9] rs2, [13:0] imm
- alu_op  out  6  to ALU, registered
- operand1  out  64  to ALU, registered
- operand2  out  64  to ALU, registered
- imm_val  out  64  to ALU, registered
- imm_type  out  2  to ALU, registered
- result  in  64  from ALU
- zero_flag  in  1  from ALU
- sign_flag  in  1  from ALU
- overflow_flag  in  1  from ALU
- wb_valid  out  1  one-cycle write-back pulse
- wb_rd  out  5  write-back index
- wb_data  out  64  write-back value
- flags_q  out  3  {overflow, sign, zero} of last retired instruction
- illegal_op  out  1  one-cycle pulse; tied 0 unless the optional feature is enabled
- dbg_addr  in  5  debug read index
- dbg_data  out  64  combinational read of regfile[dbg_addr]; 0 for index 0 or index >= NUM_REGS

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All registered outputs, flags_q, wb_* and the whole register file clear to 0.
  - instr_ready=0 while rst is high.
- FSM IDLE -> DECODE -> EXEC -> WB -> IDLE.
- IDLE:
  - instr_ready=1.
  - Accept at edge T when instr_valid & instr_ready; latch all instruction fields; go to DECODE.
  - instr_valid without ready has no effect. instr must be held stable by the source until accepted.
- DECODE (T+1):
  - operand1 <= R[rs1].
  - operand2 <= sign-extended imm when imm_type=2'b10, else R[rs2].
  - imm_val <= zero-extended imm when imm_type=2'b01, else sign-extended imm.
  - alu_op and imm_type are driven unchanged from the instruction.
  - instr_ready=0.
- EXEC (T+2):
  - ALU inputs are stable for the whole cycle.
  - result and the three flags are sampled at the end of the cycle.
- WB (T+3):
  - wb_valid=1, wb_rd=rd, wb_data=sampled result.
  - R[rd] is written at the end of the cycle, except rd=0 or rd >= NUM_REGS, which are dropped; wb_valid still pulses.
  - flags_q is updated.
- Throughput and hazards:
  - Next accept is possible at T+4, so a back-to-back dependency is guaranteed to see the written value.
  - No hazard logic is required.
- Source operand index >= NUM_REGS reads 0.
- Register 0 is never written.
- ALU outputs hold their last value in IDLE.
- Reset mid-operation (any non-IDLE state): the instruction is abandoned, no wb_valid, register file cleared.
- Legal combinations:
  - imm_type 00/10 with alu_op in {1,2,3,4,5,7}.
  - imm_type 01 with alu_op in {1,2,3,4}.
  - imm_type 11 is reserved.
  - Everything else is illegal.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: illegal combinations are detected in DECODE.
  - The FSM still passes through EXEC and WB.
  - At the WB cycle: illegal_op=1, wb_valid=0, no register or flag write.
- Undefined: no check is made. Illegal instructions issue normally; the ALU returns 0 and 0 is written back with zero_flag=1. illegal_op is constant 0.

Test Plan:
- Reset; accept {op=1 ADD, type=10, rd=1, rs1=0, imm=5} -> instr_ready low for cycles T+1..T+3, wb_valid at T+3 with wb_data=5, flags_q=3'b000, dbg_data(1)=5.
- ADD imm 14'h3FFF into rd=2 -> wb_data=64'hFFFF_FFFF_FFFF_FFFF, flags_q=3'b010.
- SUB {type=00, rd=3, rs1=1, rs2=1} after the first test -> wb_data=0, flags_q=3'b001; the next instruction is accepted exactly at T+4.
- ADD imm 7 to rd=0 -> wb_valid pulses, dbg_data(0) remains 0.
- Load r1=5, start a second instruction to rd=1, assert rst in EXEC -> no wb_valid, dbg_data(1)=0, instr_ready=1 one cycle after rst release.
- alu_op=6'd9, type=00, rd=4 (r4 preloaded 3):
  - with ILLEGAL_TRAP_EN -> illegal_op pulse at T+3, no wb_valid, r4 stays 3.
  - without -> wb_valid, r4=0, flags_q=3'b001.
